// File: rtl/dispatch_if.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_if
// Purpose  : Lane request, RS occupancy and issue/RAT result bundle between the
//            instruction queue and the dual-lane dispatch scheduler.
// Revision : 1.0  initial release
// ============================================================================
interface dispatch_if;
    logic       d0_valid;
    logic       d0_is_mul;
    logic [4:0] d0_rs1;
    logic [4:0] d0_rs2;
    logic [4:0] d0_rd;
    logic       d1_valid;
    logic       d1_is_mul;
    logic [4:0] d1_rs1;
    logic [4:0] d1_rs2;
    logic [4:0] d1_rd;
    logic [3:0] adder_busy;
    logic [3:0] mul_busy;

    logic       d0_accept;
    logic       d1_accept;
    logic [2:0] d0_tag;
    logic [2:0] d1_tag;
    logic [3:0] add_alloc;
    logic [3:0] mul_alloc;
    logic       dep_rs1;
    logic       dep_rs2;
    logic [2:0] dep_tag;
    logic       rat0_valid;
    logic       rat1_valid;
    logic [4:0] rat_rd0;
    logic [4:0] rat_rd1;
    logic [7:0] stall_count;
    logic       starve;

    // Queue/RS side: presents instructions and occupancy, consumes decisions.
    modport master (
        output d0_valid, d0_is_mul, d0_rs1, d0_rs2, d0_rd,
        output d1_valid, d1_is_mul, d1_rs1, d1_rs2, d1_rd,
        output adder_busy, mul_busy,
        input  d0_accept, d1_accept, d0_tag, d1_tag, add_alloc, mul_alloc,
        input  dep_rs1, dep_rs2, dep_tag, rat0_valid, rat1_valid,
        input  rat_rd0, rat_rd1, stall_count, starve
    );

    // Scheduler side.
    modport slave (
        input  d0_valid, d0_is_mul, d0_rs1, d0_rs2, d0_rd,
        input  d1_valid, d1_is_mul, d1_rs1, d1_rs2, d1_rd,
        input  adder_busy, mul_busy,
        output d0_accept, d1_accept, d0_tag, d1_tag, add_alloc, mul_alloc,
        output dep_rs1, dep_rs2, dep_tag, rat0_valid, rat1_valid,
        output rat_rd0, rat_rd1, stall_count, starve
    );
endinterface
`default_nettype wire

// File: rtl/dispatch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dispatch_scheduler
// Purpose  : Registered in-order dual-issue decision: RS slot allocation, tag
//            generation, lane-1 RAW detection, ordered RAT writes, stall watch.
// Revision : 1.0  initial release
// ============================================================================
module dispatch_scheduler #(
    parameter int RS_DEPTH    = 4,
    parameter int STALL_LIMIT = 15
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    dispatch_if.slave   dif
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_stall = 2'd2;

    localparam logic [7:0] c_stall_limit = 8'(STALL_LIMIT);
    localparam logic [7:0] c_stall_max   = 8'd255;

    // Slot index is 2 bits wide, so the station depth must stay at four.
    if (RS_DEPTH != 4) begin : g_depth_check
        $error("dispatch_scheduler supports RS_DEPTH == 4 only");
    end

    // Registered decision
    logic [1:0]          r_state;
    logic                r_d0_accept;
    logic                r_d1_accept;
    logic [2:0]          r_d0_tag;
    logic [2:0]          r_d1_tag;
    logic [RS_DEPTH-1:0] r_add_alloc;
    logic [RS_DEPTH-1:0] r_mul_alloc;
    logic                r_dep_rs1;
    logic                r_dep_rs2;
    logic [2:0]          r_dep_tag;
    logic [4:0]          r_rat_rd0;
    logic [4:0]          r_rat_rd1;
    logic [7:0]          r_stall_count;
    logic                r_starve;

    // Combinational decision
    logic [RS_DEPTH-1:0] w_add_free;
    logic [RS_DEPTH-1:0] w_mul_free;
    logic [RS_DEPTH-1:0] w_d0_free;
    logic [RS_DEPTH-1:0] w_d1_free;
    logic [RS_DEPTH-1:0] w_d0_oh;
    logic [RS_DEPTH-1:0] w_d1_oh;
    logic [1:0]          w_d0_idx;
    logic [1:0]          w_d1_idx;
    logic                w_d0_go;
    logic                w_d1_go;
    logic [2:0]          w_d0_tag;
    logic [2:0]          w_d1_tag;
    logic [RS_DEPTH-1:0] w_add_alloc;
    logic [RS_DEPTH-1:0] w_mul_alloc;
    logic                w_dep_rs1;
    logic                w_dep_rs2;
    logic [1:0]          w_state_nxt;
    logic [7:0]          w_stall_nxt;

    function automatic logic [1:0] f_lowest(input logic [RS_DEPTH-1:0] mask);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    // Last cycle's claims are not yet reflected in busy, so mask them out too.
    assign w_add_free = ~dif.adder_busy & ~r_add_alloc;
    assign w_mul_free = ~dif.mul_busy   & ~r_mul_alloc;

    always_comb begin
        w_d0_free = dif.d0_is_mul ? w_mul_free : w_add_free;
        w_d0_go   = dif.d0_valid && (|w_d0_free);
        w_d0_idx  = f_lowest(w_d0_free);
        w_d0_oh   = RS_DEPTH'(1) << w_d0_idx;
        w_d0_tag  = {dif.d0_is_mul, w_d0_idx};

        // Lane 1 sees its class pool minus whatever lane 0 just took from it.
        w_d1_free = dif.d1_is_mul ? w_mul_free : w_add_free;
        if (dif.d1_is_mul == dif.d0_is_mul) begin
            w_d1_free = w_d1_free & ~w_d0_oh;
        end
        w_d1_go   = w_d0_go && dif.d1_valid && (|w_d1_free);
        w_d1_idx  = f_lowest(w_d1_free);
        w_d1_oh   = RS_DEPTH'(1) << w_d1_idx;
        w_d1_tag  = {dif.d1_is_mul, w_d1_idx};

        w_add_alloc = '0;
        w_mul_alloc = '0;
        if (w_d0_go) begin
            if (dif.d0_is_mul) w_mul_alloc = w_mul_alloc | w_d0_oh;
            else               w_add_alloc = w_add_alloc | w_d0_oh;
        end
        if (w_d1_go) begin
            if (dif.d1_is_mul) w_mul_alloc = w_mul_alloc | w_d1_oh;
            else               w_add_alloc = w_add_alloc | w_d1_oh;
        end

        w_dep_rs1 = w_d1_go && (dif.d0_rd != 5'd0) && (dif.d1_rs1 == dif.d0_rd);
        w_dep_rs2 = w_d1_go && (dif.d0_rd != 5'd0) && (dif.d1_rs2 == dif.d0_rd);
    end

    always_comb begin
        w_state_nxt = c_st_idle;
        if (!dif.d0_valid) w_state_nxt = c_st_idle;
        else if (w_d0_go)  w_state_nxt = c_st_run;
        else               w_state_nxt = c_st_stall;

        w_stall_nxt = 8'd0;
        if (w_state_nxt == c_st_stall) begin
            w_stall_nxt = (r_stall_count == c_stall_max) ? c_stall_max
                                                         : r_stall_count + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_st_idle;
            r_d0_accept   <= 1'b0;
            r_d1_accept   <= 1'b0;
            r_d0_tag      <= 3'd0;
            r_d1_tag      <= 3'd0;
            r_add_alloc   <= '0;
            r_mul_alloc   <= '0;
            r_dep_rs1     <= 1'b0;
            r_dep_rs2     <= 1'b0;
            r_dep_tag     <= 3'd0;
            r_rat_rd0     <= 5'd0;
            r_rat_rd1     <= 5'd0;
            r_stall_count <= 8'd0;
            r_starve      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_d0_accept   <= w_d0_go;
            r_d1_accept   <= w_d1_go;
            r_d0_tag      <= w_d0_go ? w_d0_tag : 3'd0;
            r_d1_tag      <= w_d1_go ? w_d1_tag : 3'd0;
            r_add_alloc   <= w_add_alloc;
            r_mul_alloc   <= w_mul_alloc;
            r_dep_rs1     <= w_dep_rs1;
            r_dep_rs2     <= w_dep_rs2;
            r_dep_tag     <= (w_dep_rs1 || w_dep_rs2) ? w_d0_tag : 3'd0;
            r_rat_rd0     <= w_d0_go ? dif.d0_rd : 5'd0;
            r_rat_rd1     <= w_d1_go ? dif.d1_rd : 5'd0;
            r_stall_count <= w_stall_nxt;
            r_starve      <= (w_stall_nxt >= c_stall_limit);
        end
    end

    // RAT write strobes coincide with the accepts; the RAT orders rat1 after rat0.
    assign dif.d0_accept   = r_d0_accept;
    assign dif.d1_accept   = r_d1_accept;
    assign dif.d0_tag      = r_d0_tag;
    assign dif.d1_tag      = r_d1_tag;
    assign dif.add_alloc   = r_add_alloc;
    assign dif.mul_alloc   = r_mul_alloc;
    assign dif.dep_rs1     = r_dep_rs1;
    assign dif.dep_rs2     = r_dep_rs2;
    assign dif.dep_tag     = r_dep_tag;
    assign dif.rat0_valid  = r_d0_accept;
    assign dif.rat1_valid  = r_d1_accept;
    assign dif.rat_rd0     = r_rat_rd0;
    assign dif.rat_rd1     = r_rat_rd1;
    assign dif.stall_count = r_stall_count;
    assign dif.starve      = r_starve;

endmodule
`default_nettype wire

// File: tb/tb_dispatch_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dispatch_scheduler
// Purpose  : Directed-vector self-checking bench for dispatch_scheduler.
// Revision : 1.0  initial release
// ============================================================================
module tb_dispatch_scheduler;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    logic [2:0] rat_model [0:31];

    dispatch_if dif ();

    dispatch_scheduler #(
        .RS_DEPTH    (4),
        .STALL_LIMIT (15)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dif   (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_in();
        dif.d0_valid = 1'b0; dif.d0_is_mul = 1'b0;
        dif.d0_rs1 = 5'd0; dif.d0_rs2 = 5'd0; dif.d0_rd = 5'd0;
        dif.d1_valid = 1'b0; dif.d1_is_mul = 1'b0;
        dif.d1_rs1 = 5'd0; dif.d1_rs2 = 5'd0; dif.d1_rd = 5'd0;
        dif.adder_busy = 4'd0; dif.mul_busy = 4'd0;
    endtask

    // Advance one edge and sample 1 time unit later; the reference RAT applies rat1 last.
    task automatic step();
        @(posedge clk);
        #1;
        if (dif.rat0_valid) rat_model[dif.rat_rd0] = dif.d0_tag;
        if (dif.rat1_valid) rat_model[dif.rat_rd1] = dif.d1_tag;
    endtask

    task automatic idle();
        clear_in();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        for (int i = 0; i < 32; i++) rat_model[i] = 3'd0;
        clear_in();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_d0_accept", {31'd0, dif.d0_accept}, 32'd0);
        chk("rst_stall_cnt", {24'd0, dif.stall_count}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset mid-issue: outputs clear asynchronously, pending mask discarded.
        dif.d0_valid = 1'b1; dif.d1_valid = 1'b1;
        step();
        chk("pre_rst_d0_tag", {29'd0, dif.d0_tag}, 32'd0);
        chk("pre_rst_d1_tag", {29'd0, dif.d1_tag}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_acc", {30'd0, dif.d0_accept, dif.d1_accept}, 32'd0);
        chk("async_rst_alloc", {28'd0, dif.add_alloc}, 32'd0);
        chk("async_rst_tag", {26'd0, dif.d0_tag, dif.d1_tag}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_d0_tag", {29'd0, dif.d0_tag}, 32'd0);
        chk("post_rst_alloc", {28'd0, dif.add_alloc}, 32'h3);
        idle();

        // add/add with slots 0 and 2 busy
        dif.d0_valid = 1'b1; dif.d1_valid = 1'b1; dif.adder_busy = 4'b0101;
        step();
        chk("aa_accepts", {30'd0, dif.d0_accept, dif.d1_accept}, 32'h3);
        chk("aa_d0_tag", {29'd0, dif.d0_tag}, 32'b001);
        chk("aa_d1_tag", {29'd0, dif.d1_tag}, 32'b011);
        chk("aa_add_alloc", {28'd0, dif.add_alloc}, 32'b1010);
        idle();

        // mul/mul with one free slot: lane 0 only, then pending blocks slot 0
        dif.d0_valid = 1'b1; dif.d0_is_mul = 1'b1;
        dif.d1_valid = 1'b1; dif.d1_is_mul = 1'b1; dif.mul_busy = 4'b1110;
        step();
        chk("mm_accepts", {30'd0, dif.d0_accept, dif.d1_accept}, 32'b10);
        chk("mm_d0_tag", {29'd0, dif.d0_tag}, 32'b100);
        chk("mm_mul_alloc", {28'd0, dif.mul_alloc}, 32'b0001);
        step();
        chk("mm_pend_acc", {30'd0, dif.d0_accept, dif.d1_accept}, 32'd0);
        chk("mm_pend_stall", {24'd0, dif.stall_count}, 32'd1);
        idle();
        chk("idle_stall_clr", {24'd0, dif.stall_count}, 32'd0);

        // add then mul with RAW on rs2
        dif.d0_valid = 1'b1; dif.d0_rd = 5'd5; dif.adder_busy = 4'b0001;
        dif.d1_valid = 1'b1; dif.d1_is_mul = 1'b1; dif.d1_rs1 = 5'd3; dif.d1_rs2 = 5'd5;
        step();
        chk("raw_deps", {30'd0, dif.dep_rs1, dif.dep_rs2}, 32'b01);
        chk("raw_dep_tag", {29'd0, dif.dep_tag}, 32'b001);
        chk("raw_d1_tag", {29'd0, dif.d1_tag}, 32'b100);
        dif.d0_rd = 5'd0; dif.d1_rs2 = 5'd0;
        step();
        chk("x0_deps", {30'd0, dif.dep_rs1, dif.dep_rs2}, 32'd0);
        chk("x0_tags", {26'd0, dif.d0_tag, dif.d1_tag}, {26'd0, 3'b010, 3'b101});
        idle();

        // Lane 1 alone is ignored
        dif.d1_valid = 1'b1;
        step();
        chk("d1_only_acc", {30'd0, dif.d0_accept, dif.d1_accept}, 32'd0);
        idle();

        // Slot 3 only free, same class on both lanes
        dif.d0_valid = 1'b1; dif.d1_valid = 1'b1; dif.adder_busy = 4'b0111;
        step();
        chk("slot3_d0_tag", {29'd0, dif.d0_tag}, 32'b011);
        chk("slot3_accepts", {30'd0, dif.d0_accept, dif.d1_accept}, 32'b10);
        idle();

        // All adders busy for 20 cycles
        dif.d0_valid = 1'b1; dif.adder_busy = 4'b1111;
        for (int i = 1; i <= 20; i++) begin
            step();
            chk($sformatf("stall_acc_%0d", i), {31'd0, dif.d0_accept}, 32'd0);
            chk($sformatf("stall_cnt_%0d", i), {24'd0, dif.stall_count}, i);
            chk($sformatf("starve_%0d", i), {31'd0, dif.starve}, (i >= 15) ? 32'd1 : 32'd0);
        end
        dif.adder_busy = 4'b0000;
        step();
        chk("unstall_acc", {31'd0, dif.d0_accept}, 32'd1);
        chk("unstall_cnt", {24'd0, dif.stall_count}, 32'd0);
        chk("unstall_starve", {31'd0, dif.starve}, 32'd0);
        idle();

        // WAW on r7: lane 1's tag must win in the RAT
        dif.d0_valid = 1'b1; dif.d0_rd = 5'd7;
        dif.d1_valid = 1'b1; dif.d1_is_mul = 1'b1; dif.d1_rd = 5'd7;
        step();
        chk("waw_rat_valid", {30'd0, dif.rat0_valid, dif.rat1_valid}, 32'b11);
        chk("waw_rat_rd", {22'd0, dif.rat_rd0, dif.rat_rd1}, {22'd0, 5'd7, 5'd7});
        chk("waw_rat7", {29'd0, rat_model[7]}, 32'b100);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
